tdm_demux: RTL

- Time-division demultiplexer: the receiving end of a TDM channel mux.
- Accepts one serial stream of beats, framed by a start-of-frame marker. Each beat is steered to its own registered channel output, in round-robin order.
- Sits downstream of a TDM mux/link. Provides per-channel data plus a valid strobe, with frame-sync error detection.

---
 rtl/tdm_demux.sv | 121 ++++++++++++
 1 files changed

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: steers a SOF-framed beat stream round-robin onto
// registered per-channel outputs. Optional even-parity check via TDM_DEMUX_PARITY_EN.
module tdm_demux #(
   parameter  int DATA_W = 8,
   parameter  int NUM_CH = 4,
   localparam int CH_W   = $clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic                     in_sof,
   input  logic [DATA_W-1:0]        in_data,
   output logic [NUM_CH*DATA_W-1:0] out_data,
   output logic [NUM_CH-1:0]        out_valid,
   output logic                     frame_done,
   output logic [CH_W-1:0]          ch_idx,
   output logic                     sync_err,
   output logic                     locked
`ifdef TDM_DEMUX_PARITY_EN
   ,
   input  logic                     in_par,
   output logic                     par_err
`endif
);

   // Handshake: valid-only, no back-pressure. A beat is consumed on every edge
   // where in_valid=1; in_sof/in_data (and in_par) are ignored when in_valid=0.

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

   state_t          state_q, state_n;
   logic [CH_W-1:0] ch_idx_n;
   logic [CH_W-1:0] wr_ch;
   logic            wr_en;
   logic            frame_done_n;
   logic            sync_err_n;
   logic            par_bad;

`ifdef TDM_DEMUX_PARITY_EN
   assign par_bad = in_valid & (^{in_data, in_par});
`else
   assign par_bad = 1'b0;
`endif

   // locked doubles as the observable view of the two-state FSM.
   assign locked = (state_q == RUN);

   always_comb begin
      state_n      = state_q;
      ch_idx_n     = ch_idx;
      wr_en        = 1'b0;
      wr_ch        = '0;
      frame_done_n = 1'b0;
      sync_err_n   = 1'b0;
      if (in_valid && !par_bad) begin
         case (state_q)
            IDLE: begin
               if (in_sof) begin
                  wr_en    = 1'b1;
                  ch_idx_n = CH_W'(1);
                  state_n  = RUN;
               end
            end
            RUN: begin
               if (in_sof) begin
                  // Early SOF resyncs onto the new frame instead of dropping it.
                  wr_en      = 1'b1;
                  ch_idx_n   = CH_W'(1);
                  sync_err_n = (ch_idx != '0);
               end else if (ch_idx == '0) begin
                  sync_err_n = 1'b1;
                  state_n    = IDLE;
               end else begin
                  wr_en = 1'b1;
                  wr_ch = ch_idx;
                  if (ch_idx == LAST_CH) begin
                     ch_idx_n     = '0;
                     frame_done_n = 1'b1;
                  end else begin
                     ch_idx_n = ch_idx + 1'b1;
                  end
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ch_idx     <= '0;
         out_data   <= '0;
         out_valid  <= '0;
         frame_done <= 1'b0;
         sync_err   <= 1'b0;
      end else begin
         state_q    <= state_n;
         ch_idx     <= ch_idx_n;
         frame_done <= frame_done_n;
         sync_err   <= sync_err_n;
         out_valid  <= '0;
         for (int k = 0; k < NUM_CH; k++) begin
            if (wr_en && (wr_ch == CH_W'(k))) begin
               out_valid[k]                 <= 1'b1;
               out_data[k*DATA_W +: DATA_W] <= in_data;
            end
         end
      end
   end

`ifdef TDM_DEMUX_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst) par_err <= 1'b0;
      else     par_err <= par_bad;
   end
`endif

endmodule
